// File: rtl/eqn_serial_ctrl_if.sv
// Handshake and eq2-slice signals shared between a requester, eqn_serial_ctrl and the external eq2 slice.
// The controller side uses the slave modport; the requester/eq2 side uses master.
interface eqn_serial_ctrl_if #(
    parameter int WIDTH = 8
);
    localparam int N  = WIDTH / 2;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ready;
    logic             busy;
    logic             done;
    logic             aeqb;
    logic [IW-1:0]    mismatch_idx;
    logic [1:0]       slice_a;
    logic [1:0]       slice_b;
    logic             slice_eq;

    modport master (
        output start, a, b, slice_eq,
        input  ready, busy, done, aeqb, mismatch_idx, slice_a, slice_b
    );

    modport slave (
        input  start, a, b, slice_eq,
        output ready, busy, done, aeqb, mismatch_idx, slice_a, slice_b
    );
endinterface

// File: rtl/eqn_serial_ctrl.sv
// Word equality compare streamed 2 bits/cycle, LSB first, through one external eq2 slice.
// Optional macro EQN_EARLY_EXIT_EN: stop on the first mismatching slice instead of running all N.
//
// state  | meaning
// IDLE   | ready, slices driven 00, waiting for start
// CMP    | presenting slice idx to eq2, sampling slice_eq each edge
// DONE   | one-cycle done pulse, word result already registered
module eqn_serial_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                reset,
    eqn_serial_ctrl_if.slave    bus
);
    localparam int N  = WIDTH / 2;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CMP  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [IW-1:0]    r_idx;
    logic             r_flag;
    logic             r_aeqb;
    logic [IW-1:0]    r_mis_idx;

    logic             w_last;
    logic             w_first_mis;
    logic             w_exit;
    logic [WIDTH-1:0] w_a_shift;
    logic [WIDTH-1:0] w_b_shift;
    logic [1:0]       w_slice_a;
    logic [1:0]       w_slice_b;

    assign w_last      = (r_idx == LAST_IDX);
    assign w_first_mis = ~bus.slice_eq & ~r_flag;

`ifdef EQN_EARLY_EXIT_EN
    assign w_exit = w_last | w_first_mis;
`else
    assign w_exit = w_last;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_state_nxt = S_CMP;
                end
            end
            S_CMP: begin
                if (w_exit) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Word result is registered on the edge entering DONE so it is valid in the done cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_a       <= '0;
            r_b       <= '0;
            r_idx     <= '0;
            r_flag    <= 1'b0;
            r_aeqb    <= 1'b0;
            r_mis_idx <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_a       <= bus.a;
                        r_b       <= bus.b;
                        r_idx     <= '0;
                        r_flag    <= 1'b0;
                        r_aeqb    <= 1'b0;
                        r_mis_idx <= '0;
                    end
                end
                S_CMP: begin
                    if (w_first_mis) begin
                        r_flag    <= 1'b1;
                        r_mis_idx <= r_idx;
                    end
                    if (w_exit) begin
                        r_aeqb <= ~r_flag & bus.slice_eq;
                    end else begin
                        r_idx <= r_idx + IW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign w_a_shift = r_a >> {r_idx, 1'b0};
    assign w_b_shift = r_b >> {r_idx, 1'b0};

    always_comb begin
        w_slice_a = 2'b00;
        w_slice_b = 2'b00;
        if (r_state == S_CMP) begin
            w_slice_a = w_a_shift[1:0];
            w_slice_b = w_b_shift[1:0];
        end
    end

    assign bus.ready        = (r_state == S_IDLE);
    assign bus.busy         = (r_state == S_CMP);
    assign bus.done         = (r_state == S_DONE);
    assign bus.aeqb         = r_aeqb;
    assign bus.mismatch_idx = r_mis_idx;
    assign bus.slice_a      = w_slice_a;
    assign bus.slice_b      = w_slice_b;
endmodule

// File: doc/eqn_serial_ctrl.md
# eqn_serial_ctrl

Sequencing controller that compares two WIDTH-bit words by streaming them, 2 bits per cycle, through one shared external `eq2` 2-bit equality slice. It owns the start/ready/done handshake, latches the operands, steps the slice index LSB-first, and accumulates the per-slice equality result into a word-level result. It sits between a requesting unit and a single `eq2` instance, which stays outside this block.

## Interface
- `WIDTH`, default 8: operand width in bits. Must be even and ≥ 2. N = WIDTH/2 slices.
- `clk`  input  1  rising-edge clock.
- `reset`  input  1  asynchronous, active-high reset.
- `start`  input  1  request a compare; accepted only when `ready`=1.
- `a`  input  WIDTH  operand A; sampled on the accepting edge.
- `b`  input  WIDTH  operand B; sampled on the accepting edge.
- `ready`  output  1  high in IDLE only.
- `busy`  output  1  high in CMP only.
- `done`  output  1  one-cycle pulse in DONE.
- `aeqb`  output  1  word result: 1 = equal. Held until the next accepted start.
- `mismatch_idx`  output  max(1,$clog2(N))  index of the first mismatching slice; 0 when `aeqb`=1. Held with `aeqb`.
- `slice_a`  output  2  A slice driven to `eq2.a`.
- `slice_b`  output  2  B slice driven to `eq2.b`.
- `slice_eq`  input  1  from `eq2.aeqb`; combinational from `slice_a`/`slice_b`.

## Operation
- FSM states: IDLE, CMP, DONE.
- IDLE: `ready`=1 and `slice_a`/`slice_b`=2'b00. When `start`=1 at an edge, the block latches `a` and `b`, sets idx=0, clears the mismatch flag, clears `aeqb`, and moves to CMP.
- CMP: drives `slice_a`=A[2·idx+1:2·idx] and `slice_b`=B[2·idx+1:2·idx]. It samples `slice_eq` at each edge:
  - On a mismatch with the flag clear, the block sets the flag and records idx into `mismatch_idx`.
  - On the last slice (idx = N−1), or on the first mismatch when early exit is compiled in, the block moves to DONE. Otherwise idx increments.
- DONE: `done`=1 for exactly one cycle, `aeqb` = NOT flag, then the block returns to IDLE.
- `start` outside IDLE, including in DONE, is ignored. It is neither queued nor able to corrupt the latched operands.
- Reset mid-operation: the block returns to IDLE immediately and the in-flight result is discarded.
- Reset values: `ready`=1, `busy`=0, `done`=0, `aeqb`=0, `mismatch_idx`=0, `slice_a`=`slice_b`=2'b00. Internal operand and index registers reset to 0.

## Timing
- Start accepted at edge t0: slice 0 is presented in the cycle after t0, and slice i's result is sampled at edge t(i+1).
- Full-length compare: `done` is high in the cycle after edge tN, that is, N cycles after the accepting edge. `ready` returns the cycle after that.
- Early exit on a mismatch at slice i: `done` is high in the cycle after edge t(i+1).
- Back-to-back: the minimum start-to-start spacing is N+2 cycles without early exit.
- `aeqb` and `mismatch_idx` are registered and valid from the `done` cycle onward. They stay stable through IDLE.
- `ready`, `busy`, and `done` are decoded from the state register only.
- N=1 (WIDTH=2) is legal: one CMP cycle, and `mismatch_idx` is 1 bit wide and always 0.

## Configuration
- `EQN_EARLY_EXIT_EN` defined: CMP terminates on the first mismatching slice, so latency depends on the data.
- Undefined: CMP always runs all N slices, giving constant latency. The first-mismatch recording is identical.

## Test plan
All scenarios use WIDTH=8, so N=4.
- Reset check: assert `reset` asynchronously between edges. Required: `ready`=1, `busy`=0, `done`=0, `aeqb`=0, `mismatch_idx`=0, and slices = 00 immediately, without waiting for a clock edge.
- Equal operands: `a`=8'hA5, `b`=8'hA5, start. Required: `busy` for 4 cycles, `done` 4 cycles after the accepting edge, `aeqb`=1, `mismatch_idx`=0.
- LSB mismatch: `a`=8'hA5, `b`=8'hA4. Required: `aeqb`=0, `mismatch_idx`=0. `done` comes 1 cycle after the accepting edge with the macro defined, and 4 cycles after without it.
- MSB mismatch: `a`=8'h3C, `b`=8'h7C. Required: `done` after 4 cycles, `aeqb`=0, `mismatch_idx`=3. Also check `slice_a` sequence 00,11,11,00 and `slice_b` sequence 00,11,11,01.
- Start while busy: start with `a`=`b`=8'hFF, then pulse `start` in CMP with `a`=8'h00, `b`=8'h01. Required: the second start is ignored, `aeqb`=1, and exactly one `done` pulse.
- Reset mid-CMP: assert `reset` at slice 2, then release. Required: no `done` pulse. A new start with `a`=8'h12, `b`=8'h12 completes with `aeqb`=1.
